seg_scan_decoder: RTL and testbench

- Reader end of the multiplexed 7-segment display interface driven by the timer/stopwatch display block.
- Watches the scanned segment/segsel bus and waits for each digit position to settle.
- Decodes each settled pattern back to a hex digit, blank flag and decimal point, and assembles them into a complete 8-digit frame.
- Used on-chip for display self-check and by benches to read the displayed value without inspecting segment waveforms.

---
 rtl/seg_scan_decoder_if.sv | 26 ++
 rtl/seg_scan_decoder.sv | 132 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
// Bundles the scanned 7-segment bus and the decoded frame outputs of seg_scan_decoder.
// Latency: none, wires only.
// Backpressure: none; the display bus is free-running and the frame outputs are pulse-qualified.
// Ports: segment[7:0] (dp,g..a), segsel[7:0] digit enables, digits[31:0], blank[7:0], dp[7:0],
//        frame_valid (frame update pulse), seg_err (bad pattern / multi-hot select pulse).
interface seg_scan_decoder_if;
    logic [7:0]  segment;
    logic [7:0]  segsel;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        seg_err;

    // master drives the display bus and observes the decoded frame
    modport master (
        output segment, segsel,
        input  digits, blank, dp, frame_valid, seg_err
    );

    // slave is the decoder itself
    modport slave (
        input  segment, segsel,
        output digits, blank, dp, frame_valid, seg_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Reads a multiplexed 7-segment scan back into an 8-digit hex frame (code, blank, dp per digit).
// Latency: bus change -> sample = 1 + SETTLE_CYC cycles; last digit sample -> frame_valid = 1 cycle.
// Backpressure: none; frame_valid and seg_err are single-cycle pulses, outputs hold the last frame.
// Ports: clk, rst_n (async active-low); bus.slave carries segment/segsel in and
//        digits/blank/dp/frame_valid/seg_err out.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter bit          SEL_ACT_LOW = 1'b1,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_decoder_if.slave  bus
);

    // Idle (all-off) level of each raw bus; XOR with it normalises to active-high.
    localparam logic [7:0]  SEL_IDLE  = SEL_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0]  SEG_IDLE  = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [15:0] SAMPLE_AT = 16'(SETTLE_CYC - 1);

    logic [7:0]  seg_q, sel_q;        // input register
    logic [7:0]  seg_prev, sel_prev;  // previous registered copy, for change detection
    logic [15:0] settle_cnt;
    logic [7:0]  seen;
    logic [31:0] sh_code;
    logic [7:0]  sh_blank, sh_dp;

    logic [7:0]  sel_n, seg_n;
    logic        changed, sample, multi_hot;
    logic [5:0]  dec;
    logic [31:0] sh_code_nxt;
    logic [7:0]  sh_blank_nxt, sh_dp_nxt, seen_nxt;
    logic        err_nxt, frame_done;

    // Returns {valid, blank, code} for a lit-high gfedcba pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] lit);
        case (lit)
            7'h3F:   return 6'b10_0000;
            7'h06:   return 6'b10_0001;
            7'h5B:   return 6'b10_0010;
            7'h4F:   return 6'b10_0011;
            7'h66:   return 6'b10_0100;
            7'h6D:   return 6'b10_0101;
            7'h7D:   return 6'b10_0110;
            7'h07:   return 6'b10_0111;
            7'h7F:   return 6'b10_1000;
            7'h6F:   return 6'b10_1001;
            7'h77:   return 6'b10_1010;
            7'h7C:   return 6'b10_1011;
            7'h39:   return 6'b10_1100;
            7'h5E:   return 6'b10_1101;
            7'h79:   return 6'b10_1110;
            7'h71:   return 6'b10_1111;
            7'h00:   return 6'b11_0000;
            default: return 6'b00_0000;
        endcase
    endfunction

    always_comb begin
        sel_n        = sel_q ^ SEL_IDLE;
        seg_n        = seg_q ^ SEG_IDLE;
        changed      = {sel_q, seg_q} != {sel_prev, seg_prev};
        // a stale count is ignored on the change cycle so each stable period samples once
        sample       = !changed && (settle_cnt == SAMPLE_AT);
        multi_hot    = (sel_n & (sel_n - 8'd1)) != 8'd0;
        dec          = decode_seg(seg_n[6:0]);
        sh_code_nxt  = sh_code;
        sh_blank_nxt = sh_blank;
        sh_dp_nxt    = sh_dp;
        seen_nxt     = seen;
        err_nxt      = 1'b0;
        if (sample && (sel_n != 8'd0)) begin
            if (multi_hot) begin
                err_nxt = 1'b1;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (sel_n[i]) begin
                        sh_code_nxt[4*i +: 4] = dec[3:0];
                        sh_blank_nxt[i]       = dec[4];
                        sh_dp_nxt[i]          = seg_n[7];
                        seen_nxt[i]           = 1'b1;
                    end
                end
                // undecodable patterns are still stored (as code 0, not blank)
                err_nxt = !dec[5];
            end
        end
        // completing sample is folded in directly so frame_valid lands one cycle later
        frame_done = (seen_nxt == 8'hFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q           <= SEG_IDLE;
            sel_q           <= SEL_IDLE;
            seg_prev        <= SEG_IDLE;
            sel_prev        <= SEL_IDLE;
            settle_cnt      <= 16'd0;
            seen            <= 8'd0;
            sh_code         <= 32'd0;
            sh_blank        <= 8'd0;
            sh_dp           <= 8'd0;
            bus.digits      <= 32'd0;
            bus.blank       <= 8'hFF;
            bus.dp          <= 8'd0;
            bus.frame_valid <= 1'b0;
            bus.seg_err     <= 1'b0;
        end else begin
            seg_q    <= bus.segment;
            sel_q    <= bus.segsel;
            seg_prev <= seg_q;
            sel_prev <= sel_q;
            if (changed) begin
                settle_cnt <= 16'd0;
            end else if (settle_cnt != 16'hFFFF) begin
                settle_cnt <= settle_cnt + 16'd1;
            end
            sh_code         <= sh_code_nxt;
            sh_blank        <= sh_blank_nxt;
            sh_dp           <= sh_dp_nxt;
            seen            <= frame_done ? 8'd0 : seen_nxt;
            bus.frame_valid <= frame_done;
            bus.seg_err     <= err_nxt;
            if (frame_done) begin
                bus.digits <= sh_code_nxt;
                bus.blank  <= sh_blank_nxt;
                bus.dp     <= sh_dp_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with default parameters (SETTLE_CYC=4, active-low buses).
// Latency: inputs driven 1 time unit after the rising edge, outputs observed on the falling edge.
// Backpressure: not applicable.
module tb_seg_scan_decoder;

    logic clk;
    logic rst_n;
    seg_scan_decoder_if bus ();

    seg_scan_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int fv_cnt  = 0;
    int err_cnt = 0;
    int fv_cyc  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
        end
        if (bus.seg_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int n);
        bus.segsel  = sel;
        bus.segment = seg;
        step(n);
    endtask

    task automatic scan(input int idx, input logic [7:0] seg, input int n);
        logic [7:0] sel;
        sel      = 8'hFF;
        sel[idx] = 1'b0;
        drive(sel, seg, n);
    endtask

    // active-low patterns for "0".."7" (dp off)
    logic [7:0] pat_lo [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    // active-low patterns for "1".."8"
    logic [7:0] pat_1to8 [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    // A, b, "0"+dp, C, d, E, F, blank
    logic [7:0] pat_mix [8] = '{8'h88, 8'h83, 8'h40, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hFF};

    initial begin
        int f0, e0, c0;
        logic [7:0] prev;

        rst_n       = 1'b0;
        bus.segsel  = 8'hFF;
        bus.segment = 8'hFF;
        step(3);
        check("rst_digits", bus.digits, 32'h0);
        check("rst_blank", {24'h0, bus.blank}, 32'hFF);
        check("rst_dp", {24'h0, bus.dp}, 32'h0);
        check("rst_fv", {31'h0, bus.frame_valid}, 32'h0);
        check("rst_err", {31'h0, bus.seg_err}, 32'h0);
        rst_n = 1'b1;
        step(3);

        // static "12345678", 8 cycles per digit
        f0 = fv_cnt; e0 = err_cnt;
        for (int i = 0; i < 7; i++) scan(i, pat_1to8[i], 8);
        c0 = cyc;
        scan(7, pat_1to8[7], 8);
        drive(8'hFF, 8'hFF, 4);
        check("s12_fv_count", fv_cnt - f0, 1);
        check("s12_fv_latency", fv_cyc, c0 + 6);
        check("s12_digits", bus.digits, 32'h87654321);
        check("s12_blank", {24'h0, bus.blank}, 32'h0);
        check("s12_dp", {24'h0, bus.dp}, 32'h0);
        check("s12_err", err_cnt - e0, 0);

        // blank digit 7, "0." on digit 2, letters elsewhere
        f0 = fv_cnt;
        for (int i = 0; i < 8; i++) scan(i, pat_mix[i], 8);
        drive(8'hFF, 8'hFF, 4);
        check("mix_fv_count", fv_cnt - f0, 1);
        check("mix_digits", bus.digits, 32'h0FEDC0BA);
        check("mix_blank", {24'h0, bus.blank}, 32'h80);
        check("mix_dp", {24'h0, bus.dp}, 32'h04);

        // ghosting: segment lags segsel by one cycle, then 3 stable cycles
        f0 = fv_cnt; e0 = err_cnt;
        prev = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            scan(i, prev, 1);
            scan(i, pat_lo[i], 3);
            prev = pat_lo[i];
        end
        drive(8'hFF, 8'hFF, 8);
        check("ghost_no_frame", fv_cnt - f0, 0);
        check("ghost_no_err", err_cnt - e0, 0);
        // 5-cycle holds sample each digit once
        for (int i = 0; i < 7; i++) scan(i, pat_lo[i], 5);
        check("hold5_partial", fv_cnt - f0, 0);
        scan(7, pat_lo[7], 5);
        drive(8'hFF, 8'hFF, 4);
        check("hold5_fv_count", fv_cnt - f0, 1);
        check("hold5_digits", bus.digits, 32'h76543210);

        // errors: bad pattern 0x49 (lit) on digit 3, multi-hot select mid-frame
        f0 = fv_cnt; e0 = err_cnt;
        for (int i = 2; i < 8; i++) scan(i, (i == 3) ? 8'hB6 : 8'h8E, 8);
        drive(8'hFC, 8'hC0, 8);
        check("err_no_frame", fv_cnt - f0, 0);
        check("err_count", err_cnt - e0, 2);
        scan(0, 8'h8E, 8);
        scan(1, 8'h8E, 8);
        drive(8'hFF, 8'hFF, 4);
        check("err_fv_count", fv_cnt - f0, 1);
        check("err_digits", bus.digits, 32'hFFFF0FFF);
        check("err_blank", {24'h0, bus.blank}, 32'h0);

        // rescan: digit 0 shows 3 then 9 before the frame completes
        f0 = fv_cnt;
        scan(0, 8'hB0, 8);
        for (int i = 1; i < 7; i++) scan(i, 8'hA4, 8);
        scan(0, 8'h90, 8);
        check("rescan_partial", fv_cnt - f0, 0);
        scan(7, 8'hA4, 8);
        drive(8'hFF, 8'hFF, 4);
        check("rescan_fv_count", fv_cnt - f0, 1);
        check("rescan_digits", bus.digits, 32'h22222229);

        // reset mid-scan discards the partial frame
        for (int i = 0; i < 4; i++) scan(i, 8'h88, 8);
        scan(4, 8'h88, 2);
        rst_n = 1'b0;
        #2;
        check("mid_rst_digits", bus.digits, 32'h0);
        check("mid_rst_blank", {24'h0, bus.blank}, 32'hFF);
        check("mid_rst_dp", {24'h0, bus.dp}, 32'h0);
        check("mid_rst_fv", {31'h0, bus.frame_valid}, 32'h0);
        check("mid_rst_err", {31'h0, bus.seg_err}, 32'h0);
        step(2);
        rst_n = 1'b1;
        f0 = fv_cnt;
        for (int i = 4; i < 8; i++) scan(i, 8'h88, 8);
        drive(8'hFF, 8'hFF, 6);
        check("post_rst_no_frame", fv_cnt - f0, 0);
        for (int i = 0; i < 8; i++) scan(i, 8'h88, 8);
        drive(8'hFF, 8'hFF, 4);
        check("post_rst_fv_count", fv_cnt - f0, 1);
        check("post_rst_digits", bus.digits, 32'hAAAAAAAA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
